// File: rtl/mux_cfg_ctrl.sv
// Byte-command configuration controller for an N-output mux: shadow selector/enable
// registers written by commands, copied to the active outputs on COMMIT, with read-back.
module mux_cfg_ctrl #(
    parameter int unsigned INPUT_COUNT  = 4,
    parameter int unsigned OUTPUT_COUNT = 4,
    parameter int unsigned ARG_TIMEOUT  = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                cmd_data,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    output logic [7:0]                rsp_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [4*OUTPUT_COUNT-1:0] selectors,
    output logic [OUTPUT_COUNT-1:0]   enabled_out,
    output logic                      dirty,
    output logic                      err,
    output logic [7:0]                err_count
);
    typedef enum logic [1:0] {IDLE, ARG, RESP} state_t;
    state_t state, state_next;

    logic [4*OUTPUT_COUNT-1:0] shadow_sel;
    logic [OUTPUT_COUNT-1:0]   shadow_en;
    logic [3:0]                arg_idx;
    logic [15:0]               tmo_cnt;
    logic [3:0]                opcode, idx;
    logic                      idx_ok, arg_ok, tmo_hit;
    logic                      reject, wr_sel, en_set, en_clr, do_commit, do_read;
    logic [7:0]                rd_byte;

    assign opcode    = cmd_data[7:4];
    assign idx       = cmd_data[3:0];
    assign idx_ok    = 32'(idx) < OUTPUT_COUNT;
    assign arg_ok    = 32'(idx) < INPUT_COUNT;
    assign tmo_hit   = (32'(tmo_cnt) + 32'd1) >= ARG_TIMEOUT;
    // Gated by rst so a pending response cannot complete a handshake while in reset.
    assign rsp_valid = (state == RESP) && !rst;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        reject     = 1'b0;
        wr_sel     = 1'b0;
        en_set     = 1'b0;
        en_clr     = 1'b0;
        do_commit  = 1'b0;
        do_read    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid && !rst) begin
                    case (opcode)
                        4'h1: if (idx_ok) state_next = ARG; else reject = 1'b1;
                        4'h2: if (idx_ok) en_set = 1'b1; else reject = 1'b1;
                        4'h3: if (idx_ok) en_clr = 1'b1; else reject = 1'b1;
                        4'h4: do_commit = 1'b1;
                        4'h5: begin
                            if (idx_ok) begin
                                do_read    = 1'b1;
                                state_next = RESP;
                            end else begin
                                reject = 1'b1;
                            end
                        end
                        default: reject = 1'b1;
                    endcase
                end
            end
            ARG: begin
                cmd_ready = !rst;
                // An arriving byte wins over a timeout expiring in the same cycle.
                if (cmd_valid && !rst) begin
                    if (arg_ok) wr_sel = 1'b1;
                    else        reject = 1'b1;
                    state_next = IDLE;
                end else if (tmo_hit) begin
                    reject     = 1'b1;
                    state_next = IDLE;
                end
            end
            RESP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_byte = '0;
        for (int unsigned k = 0; k < OUTPUT_COUNT; k++) begin
            if (32'(idx) == k) rd_byte = {shadow_en[k], 3'b000, shadow_sel[4*k +: 4]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_sel  <= '0;
            shadow_en   <= '0;
            selectors   <= '0;
            enabled_out <= '0;
            dirty       <= 1'b0;
            err         <= 1'b0;
            err_count   <= '0;
            rsp_data    <= '0;
            arg_idx     <= '0;
            tmo_cnt     <= '0;
        end else begin
            err <= reject;
            if (reject && err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (state == ARG && !cmd_valid) tmo_cnt <= tmo_cnt + 16'd1;
            else                            tmo_cnt <= '0;
            if (state == IDLE && state_next == ARG) arg_idx <= idx;
            for (int unsigned k = 0; k < OUTPUT_COUNT; k++) begin
                if (wr_sel && 32'(arg_idx) == k) shadow_sel[4*k +: 4] <= idx;
                if (en_set && 32'(idx) == k)     shadow_en[k] <= 1'b1;
                if (en_clr && 32'(idx) == k)     shadow_en[k] <= 1'b0;
            end
            if (wr_sel || en_set || en_clr) dirty <= 1'b1;
            if (do_commit) begin
                selectors   <= shadow_sel;
                enabled_out <= shadow_en;
                dirty       <= 1'b0;
            end
            if (do_read) rsp_data <= rd_byte;
        end
    end
endmodule

// File: tb/tb_mux_cfg_ctrl.sv
// Self-checking bench for mux_cfg_ctrl: table vectors, directed corner sequences and
// randomized traffic, all compared against a command-level reference model.
module tb_mux_cfg_ctrl;
    localparam int IN_N  = 4;
    localparam int OUT_N = 4;
    localparam int TMO   = 8;

    logic             clk = 1'b0;
    logic             rst, cmd_valid, cmd_ready, rsp_valid, rsp_ready, dirty, err;
    logic [7:0]       cmd_data, rsp_data, err_count;
    logic [4*OUT_N-1:0] selectors;
    logic [OUT_N-1:0] enabled_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_cfg_ctrl #(.INPUT_COUNT(IN_N), .OUTPUT_COUNT(OUT_N), .ARG_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .rsp_data(rsp_data), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .selectors(selectors), .enabled_out(enabled_out),
        .dirty(dirty), .err(err), .err_count(err_count)
    );

    // Reference model: configuration tables plus "what is the controller waiting for".
    int sh_sel[OUT_N];
    int act_sel[OUT_N];
    bit sh_en[OUT_N];
    bit act_en[OUT_N];
    bit m_dirty, m_err, want_arg, rsp_pend;
    int m_cnt, arg_tgt, arg_wait, rsp_byte;

    task automatic model_reset();
        for (int k = 0; k < OUT_N; k++) begin
            sh_sel[k] = 0; act_sel[k] = 0; sh_en[k] = 0; act_en[k] = 0;
        end
        m_dirty = 0; m_err = 0; want_arg = 0; rsp_pend = 0;
        m_cnt = 0; arg_tgt = 0; arg_wait = 0; rsp_byte = 0;
    endtask

    function automatic int exp_sel();
        int v = 0;
        for (int k = 0; k < OUT_N; k++) v += act_sel[k] << (4 * k);
        return v;
    endfunction

    function automatic int exp_en();
        int v = 0;
        for (int k = 0; k < OUT_N; k++) v += int'(act_en[k]) << k;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // One clock cycle: drive, check handshake outputs, advance the model, check registers.
    task automatic tick(input logic r, input logic v, input logic [7:0] d, input logic rr);
        bit rej;
        int op, ix;
        rst = r; cmd_valid = v; cmd_data = d; rsp_ready = rr;
        #1;
        chk("cmd_ready", int'(cmd_ready), int'(!r && !rsp_pend));
        chk("rsp_valid", int'(rsp_valid), int'(!r && rsp_pend));
        if (!r && rsp_pend) chk("rsp_data", int'(rsp_data), rsp_byte);
        rej = 0;
        op  = int'(d[7:4]);
        ix  = int'(d[3:0]);
        if (r) begin
            model_reset();
        end else begin
            if (rsp_pend) begin
                if (rr) rsp_pend = 0;
            end else if (want_arg) begin
                if (v) begin
                    want_arg = 0;
                    if (ix < IN_N) begin sh_sel[arg_tgt] = ix; m_dirty = 1; end
                    else rej = 1;
                end else begin
                    arg_wait++;
                    if (arg_wait == TMO) begin want_arg = 0; rej = 1; end
                end
            end else if (v) begin
                if (op == 4) begin
                    for (int k = 0; k < OUT_N; k++) begin
                        act_sel[k] = sh_sel[k]; act_en[k] = sh_en[k];
                    end
                    m_dirty = 0;
                end else if (op >= 1 && op <= 5 && ix < OUT_N) begin
                    case (op)
                        1: begin want_arg = 1; arg_tgt = ix; arg_wait = 0; end
                        2: begin sh_en[ix] = 1; m_dirty = 1; end
                        3: begin sh_en[ix] = 0; m_dirty = 1; end
                        default: begin rsp_pend = 1; rsp_byte = (sh_en[ix] ? 128 : 0) + sh_sel[ix]; end
                    endcase
                end else begin
                    rej = 1;
                end
            end
            m_err = rej;
            if (rej && m_cnt < 255) m_cnt++;
        end
        @(posedge clk);
        #1;
        chk("selectors", int'(selectors), exp_sel());
        chk("enabled_out", int'(enabled_out), exp_en());
        chk("dirty", int'(dirty), int'(m_dirty));
        chk("err", int'(err), int'(m_err));
        chk("err_count", int'(err_count), m_cnt);
    endtask

    typedef struct {
        logic [7:0]         d;
        logic [4*OUT_N-1:0] sel;
        logic [OUT_N-1:0]   en;
        logic               dty;
    } vec_t;
    vec_t vecs[9];

    logic [3:0] op4, ix4;
    int pv;

    initial begin
        vecs[0] = '{8'h11, 16'h0000, 4'b0000, 1'b0};
        vecs[1] = '{8'h02, 16'h0000, 4'b0000, 1'b1};
        vecs[2] = '{8'h21, 16'h0000, 4'b0000, 1'b1};
        vecs[3] = '{8'h40, 16'h0020, 4'b0010, 1'b0};
        vecs[4] = '{8'h21, 16'h0020, 4'b0010, 1'b1};
        vecs[5] = '{8'h22, 16'h0020, 4'b0010, 1'b1};
        vecs[6] = '{8'h40, 16'h0020, 4'b0110, 1'b0};
        vecs[7] = '{8'h31, 16'h0020, 4'b0110, 1'b1};
        vecs[8] = '{8'h40, 16'h0020, 4'b0100, 1'b0};

        model_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; rsp_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset with a byte presented: must not be accepted.
        tick(1, 1, 8'h21, 0);
        tick(1, 1, 8'h21, 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_selectors", int'(selectors), 0);
        chk("rst_err_count", int'(err_count), 0);

        // Set/enable/commit then back-to-back enables and commits.
        for (int i = 0; i < 9; i++) begin
            tick(0, 1, vecs[i].d, 0);
            chk($sformatf("vec%0d_sel", i), int'(selectors), int'(vecs[i].sel));
            chk($sformatf("vec%0d_en", i), int'(enabled_out), int'(vecs[i].en));
            chk($sformatf("vec%0d_dirty", i), int'(dirty), int'(vecs[i].dty));
        end

        // Shadow write without commit, then a read held off by rsp_ready.
        tick(1, 0, 8'h00, 0);
        tick(0, 1, 8'h10, 0);
        tick(0, 1, 8'h03, 0);
        chk("nocommit_sel", int'(selectors), 0);
        chk("nocommit_dirty", int'(dirty), 1);
        tick(0, 1, 8'h50, 0);
        for (int i = 0; i < 5; i++) begin
            tick(0, 1, 8'h21, 0);
            chk("hold_valid", int'(rsp_valid), 1);
            chk("hold_ready", int'(cmd_ready), 0);
            chk("hold_data", int'(rsp_data), 8'h03);
        end
        tick(0, 0, 8'h00, 1);
        chk("after_hs_valid", int'(rsp_valid), 0);

        // Rejections and err pulse shape.
        tick(1, 0, 8'h00, 0);
        tick(0, 1, 8'h14, 0);
        chk("rej_idx_err", int'(err), 1);
        tick(0, 1, 8'h70, 0);
        chk("rej_op_err", int'(err), 1);
        tick(0, 1, 8'h10, 0);
        chk("rej_gap_err", int'(err), 0);
        tick(0, 1, 8'h09, 0);
        chk("rej_arg_err", int'(err), 1);
        chk("rej_count3", int'(err_count), 3);
        tick(0, 1, 8'h10, 0);
        tick(0, 1, 8'h04, 0);
        chk("rej_arg_bound", int'(err), 1);
        tick(0, 1, 8'h50, 0);
        chk("rej_shadow", int'(rsp_data), 8'h00);
        tick(0, 0, 8'h00, 1);
        for (int i = 0; i < 300; i++) tick(0, 1, 8'h00, 0);
        chk("err_sat", int'(err_count), 255);

        // Argument timeout and last-cycle arrival.
        tick(1, 0, 8'h00, 0);
        tick(0, 1, 8'h12, 0);
        for (int i = 0; i < TMO; i++) begin
            tick(0, 0, 8'h00, 0);
            chk($sformatf("tmo_err_%0d", i), int'(err), (i == TMO - 1) ? 1 : 0);
        end
        tick(0, 1, 8'h21, 0);
        chk("tmo_idle_ready", int'(cmd_ready), 1);
        tick(0, 1, 8'h12, 0);
        for (int i = 0; i < TMO - 1; i++) tick(0, 0, 8'h00, 0);
        tick(0, 1, 8'h03, 0);
        chk("late_arg_err", int'(err), 0);
        tick(0, 1, 8'h52, 0);
        chk("late_arg_read", int'(rsp_data), 8'h03);
        tick(0, 0, 8'h00, 1);

        // Reset aborts a pending SET_SEL.
        tick(0, 1, 8'h13, 0);
        tick(1, 0, 8'h00, 0);
        tick(0, 1, 8'h01, 0);
        chk("abort_err", int'(err), 1);
        tick(0, 1, 8'h53, 0);
        chk("abort_read", int'(rsp_data), 8'h00);
        tick(0, 0, 8'h00, 1);

        // Randomized traffic: dense first, then sparse to exercise timeouts.
        for (int n = 0; n < 600; n++) begin
            pv  = (n < 350) ? 70 : 12;
            op4 = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 5)) : 4'($urandom_range(0, 15));
            ix4 = ($urandom_range(0, 7) != 0) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 15));
            tick($urandom_range(0, 99) == 0, $urandom_range(0, 99) < pv,
                 {op4, ix4}, $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux_cfg_ctrl.md
MUX_CFG_CTRL -- requirements
Module: mux_cfg_ctrl

Interface
REQ-001 Parameter INPUT_COUNT, default 4, number of mux inputs (1..16).
REQ-002 Parameter OUTPUT_COUNT, default 4, number of mux outputs (1..16).
REQ-003 Parameter ARG_TIMEOUT, default 255, max cycles waiting for a command argument byte (1..65535).
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cmd_data  input  8  command byte.
REQ-007 cmd_valid  input  1  cmd_data valid.
REQ-008 cmd_ready  output  1  controller accepts byte; transfer when cmd_valid && cmd_ready.
REQ-009 rsp_data  output  8  read response byte.
REQ-010 rsp_valid  output  1  rsp_data valid.
REQ-011 rsp_ready  input  1  consumer takes response when rsp_valid && rsp_ready.
REQ-012 selectors  output  4*OUTPUT_COUNT  active selector per output; output k uses bits [4k+3:4k]; drives mux selector input.
REQ-013 enabled_out  output  OUTPUT_COUNT  active per-output enable; drives mux enable input.
REQ-014 dirty  output  1  shadow config differs from active config (pending commit).
REQ-015 err  output  1  one-cycle pulse on a rejected command.
REQ-016 err_count  output  8  saturating count of rejected commands.

Function
REQ-017 Command byte layout: opcode = cmd_data[7:4], idx = cmd_data[3:0].
REQ-018 Opcode 0x1 SET_SEL: two bytes; second byte holds input index in [3:0], [7:4] ignored; writes shadow selector of output idx.
REQ-019 Opcode 0x2 ENABLE: sets shadow enable bit idx; 0x3 DISABLE: clears it.
REQ-020 Opcode 0x4 COMMIT: idx ignored; copies all shadow selectors and enables to selectors/enabled_out, updated on the clock edge following acceptance (visible 1 cycle after the accept cycle), all outputs changing in the same cycle.
REQ-021 Opcode 0x5 READ: response byte = {shadow_enable[idx], 3'b000, shadow_sel[idx]}.
REQ-022 FSM states IDLE, ARG, RESP; reset state IDLE.
REQ-023 IDLE: cmd_ready=1; SET_SEL with valid idx -> ARG; valid READ -> RESP; other valid opcodes execute in the accept cycle and stay in IDLE.
REQ-024 ARG: cmd_ready=1; accepted byte with input index < INPUT_COUNT writes shadow, -> IDLE; input index >= INPUT_COUNT -> err, no write, -> IDLE.
REQ-025 ARG timeout counter clears on entry and increments each cycle without an accepted byte; reaching ARG_TIMEOUT -> err, no write, -> IDLE.
REQ-026 A byte accepted in the same cycle the counter reaches ARG_TIMEOUT is processed normally; timeout does not fire.
REQ-027 RESP: cmd_ready=0, rsp_valid=1, rsp_data stable until rsp_ready; on handshake -> IDLE the next cycle; rsp_valid=0 in all other states.
REQ-028 Rejected: opcode 0x0 or 0x6..0xF, or idx >= OUTPUT_COUNT for opcodes 0x1/0x2/0x3/0x5; rejected bytes cause no state change beyond err.
REQ-029 err pulses high for exactly the cycle after the rejection; err_count increments by 1 per rejection and holds at 255.
REQ-030 dirty sets on any accepted shadow write (SET_SEL second byte, ENABLE, DISABLE), even if the value is unchanged; clears on COMMIT; COMMIT with dirty=0 is legal and rewrites identical values.
REQ-031 Active selectors/enabled_out change only on COMMIT or reset.

Reset
REQ-032 rst=1: state IDLE, all shadow and active selectors 0, all enables 0, dirty 0, err 0, err_count 0, rsp_valid 0, rsp_data 0, timeout counter 0.
REQ-033 cmd_ready=0 while rst=1; a byte presented during reset is not accepted.
REQ-034 Reset in ARG or RESP aborts the command; a pending response is discarded with no handshake.

Verification
REQ-035 After reset: send 0x11,0x02,0x21,0x40 -> selectors[7:4]=2 and enabled_out=4'b0010 exactly 1 cycle after 0x40 is accepted; dirty 1 after 0x21, 0 after 0x40.
REQ-036 Send 0x10,0x03 without COMMIT -> selectors stay 0, dirty=1; then 0x50 -> rsp_data=0x03; hold rsp_ready=0 for 5 cycles -> rsp_valid stays 1, cmd_ready stays 0, rsp_data stable.
REQ-037 Send 0x14 (idx 4), 0x70, then 0x10,0x09 -> three err pulses, err_count=3, shadow unchanged; 300 rejects -> err_count=255.
REQ-038 With ARG_TIMEOUT=8: send 0x12 then idle 8 cycles -> err pulse, FSM IDLE; second byte arriving on the 8th cycle -> accepted, no err.
REQ-039 Send 0x13 then assert rst for 1 cycle, then 0x01 -> byte treated as opcode 0x0 (err), no shadow write to output 3.
REQ-040 Back-to-back cmd_valid=1 every cycle: 0x21,0x22,0x40,0x31,0x40 -> enabled_out=4'b0110 then 4'b0100, no dropped bytes.
